// File: rtl/l2_sram_arbiter.sv
// Arbitrates NumPorts requesters onto one single-ported L2 SRAM.
// Round-robin with a per-owner burst limit, and a one-cycle response pipeline.
module l2_sram_arbiter #(
    parameter  int NumPorts    = 2,
    parameter  int L2AddrWidth = 18,
    parameter  int DataWidth   = 64,
    parameter  int MaxBurst    = 4,
    localparam int StrbWidth   = DataWidth / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumPorts-1:0]                   req_i,
    input  logic [NumPorts-1:0][L2AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0]                   we_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumPorts-1:0][StrbWidth-1:0]    be_i,
    output logic [NumPorts-1:0]                   gnt_o,
    output logic [NumPorts-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [L2AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                  mem_wdata_o,
    output logic [StrbWidth-1:0]                  mem_be_o,
    input  logic [DataWidth-1:0]                  mem_rdata_i,
    output logic                                  busy_o
);

    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CntW  = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    logic [PortW-1:0]    r_owner;
    logic                r_owner_vld;
    logic [CntW-1:0]     r_burst_cnt;
    logic [NumPorts-1:0] r_rvalid;
    logic                r_rd;

    logic                w_hold;
    logic                w_sel_vld;
    logic [PortW-1:0]    w_sel_idx;
    logic [PortW-1:0]    w_cand;
    logic                w_any;
    logic [NumPorts-1:0] w_gnt;

    // Owner hold only applies once a real grant has happened, so the first
    // grant after reset scans from port 0 (owner resets to NumPorts-1).
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_hold    = 1'b0;
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        if (r_owner_vld && req_i[r_owner] && (int'(r_burst_cnt) < MaxBurst - 1)) begin
            w_hold    = 1'b1;
            w_sel_vld = 1'b1;
            w_sel_idx = r_owner;
        end else begin
            for (int k = 1; k <= NumPorts; k++) begin
                w_cand = PortW'((int'(r_owner) + k) % NumPorts);
                if (!w_sel_vld && req_i[w_cand]) begin
                    w_sel_vld = 1'b1;
                    w_sel_idx = w_cand;
                end
            end
        end
    end

    assign w_any = w_sel_vld && !rst_i;

    always_comb begin
        w_gnt       = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_any) begin
            w_gnt[w_sel_idx] = 1'b1;
            mem_we_o         = we_i[w_sel_idx];
            mem_addr_o       = addr_i[w_sel_idx];
            mem_wdata_o      = wdata_i[w_sel_idx];
            mem_be_o         = be_i[w_sel_idx];
        end
    end

    assign gnt_o     = w_gnt;
    assign mem_req_o = w_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner     <= PortW'(NumPorts - 1);
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
            r_rvalid    <= '0;
            r_rd        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_rvalid <= w_gnt;
            r_rd     <= w_any && !mem_we_o;
            if (w_any) begin
                r_owner     <= w_sel_idx;
                r_owner_vld <= 1'b1;
                r_burst_cnt <= w_hold ? r_burst_cnt + 1'b1 : '0;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rd ? mem_rdata_i : '0;
    assign busy_o   = (|req_i) || (|r_rvalid);

endmodule

// File: tb/tb_l2_sram_arbiter.sv
// Self-checking bench for l2_sram_arbiter: table-driven vectors with a
// response scoreboard, plus hand sequences for reset, burst and 3-port cases.
module tb_l2_sram_arbiter;

    logic clk, rst;

    logic [1:0]        req, we, gnt, rvalid;
    logic [1:0][17:0]  addr;
    logic [1:0][63:0]  wdata;
    logic [1:0][7:0]   be;
    logic [63:0]       rdata, mem_wdata, mem_rdata;
    logic              mem_req, mem_we, busy;
    logic [17:0]       mem_addr;
    logic [7:0]        mem_be;

    logic [2:0]        req3, we3, gnt3, rvalid3;
    logic [2:0][7:0]   addr3;
    logic [2:0][15:0]  wdata3;
    logic [2:0][1:0]   be3;
    logic [15:0]       rdata3, mem_wdata3, mem_rdata3;
    logic              mem_req3, mem_we3, busy3;
    logic [7:0]        mem_addr3;
    logic [1:0]        mem_be3;

    l2_sram_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    l2_sram_arbiter #(.NumPorts(3), .L2AddrWidth(8), .DataWidth(16), .MaxBurst(1)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .addr_i(addr3), .we_i(we3),
        .wdata_i(wdata3), .be_i(be3), .gnt_o(gnt3), .rvalid_o(rvalid3),
        .rdata_o(rdata3), .mem_req_o(mem_req3), .mem_we_o(mem_we3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_be_o(mem_be3),
        .mem_rdata_i(mem_rdata3), .busy_o(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model driven only by the DUT command outputs.
    logic [63:0] sram    [256];
    logic [63:0] ref_mem [256];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end
    assign mem_rdata3 = '0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [17:0] a0, a1;
        logic [63:0] d0, d1;
        logic [7:0]  b0, b1;
        logic [1:0]  gnt;
    } vec_t;

    typedef struct {
        logic [1:0]  rvalid;
        logic [63:0] rdata;
    } resp_t;

    vec_t  vq[$];
    resp_t sb[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] r, input logic [1:0] w, input logic [17:0] a0,
                       input logic [17:0] a1, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] g);
        vec_t v;
        v.req = r; v.we = w; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.gnt = g;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; be3 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pop_resp(input string tag);
        resp_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_rvalid"}, 64'(rvalid), 64'(r.rvalid));
            check({tag, "_rdata"}, rdata, r.rdata);
        end
    endtask

    initial begin
        vec_t        v;
        resp_t       r;
        int          p;
        logic        any;
        logic [1:0]  prev_gnt;
        int          exp_burst[6];
        logic [1:0]  exp_g[10];

        for (int i = 0; i < 256; i++) begin
            sram[i]    = {32'(i) ^ 32'hA5A5_0000, 32'(i * 3 + 7)};
            ref_mem[i] = {32'(i) ^ 32'hA5A5_0000, 32'(i * 3 + 7)};
        end
        mem_rdata = '0;
        rst = 1'b1;
        idle_inputs();

        // Reset state: outputs quiet, busy follows req only.
        @(negedge clk);
        req = 2'b11;
        #3;
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        check("rst_rdata", rdata, 64'h0);
        check("rst_busy_req", 64'(busy), 64'h1);
        @(negedge clk);
        req = 2'b00;
        #3;
        check("rst_busy_idle", 64'(busy), 64'h0);
        rst = 1'b0;

        // Burst-limited round robin on two contending readers.
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 10; i++) add(2'b11, 2'b00, 18'h1, 18'h2, 0, 0, 8'hFF, 8'hFF, exp_g[i]);
        add(2'b01, 2'b01, 18'h10, 18'h0, 64'hDEAD_BEEF_0000_0001, 0, 8'hFF, 8'h00, 2'b01);
        add(2'b10, 2'b00, 18'h0, 18'h10, 0, 0, 8'h00, 8'h00, 2'b10);
        add(2'b00, 2'b00, 18'h0, 18'h0, 0, 0, 8'h00, 8'h00, 2'b00);
        add(2'b01, 2'b01, 18'h20, 18'h0, 64'h1122_3344_5566_7788, 0, 8'h0F, 8'h00, 2'b01);
        add(2'b01, 2'b00, 18'h20, 18'h0, 0, 0, 8'h00, 8'h00, 2'b01);
        add(2'b00, 2'b00, 18'h0, 18'h0, 0, 0, 8'h00, 8'h00, 2'b00);
        add(2'b00, 2'b00, 18'h0, 18'h0, 0, 0, 8'h00, 8'h00, 2'b00);
        add(2'b11, 2'b11, 18'h30, 18'h31, 64'hAAAA_0000_AAAA_0030, 64'hBBBB_1111_BBBB_0031, 8'hFF, 8'hFF, 2'b01);
        add(2'b10, 2'b10, 18'h0, 18'h31, 0, 64'hBBBB_1111_BBBB_0031, 8'h00, 8'hFF, 2'b10);
        add(2'b11, 2'b00, 18'h30, 18'h31, 0, 0, 8'h00, 8'h00, 2'b10);
        add(2'b01, 2'b00, 18'h30, 18'h0, 0, 0, 8'h00, 8'h00, 2'b01);
        add(2'b00, 2'b00, 18'h0, 18'h0, 0, 0, 8'h00, 8'h00, 2'b00);

        prev_gnt = 2'b00;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            req = v.req; we = v.we;
            addr[0] = v.a0; addr[1] = v.a1;
            wdata[0] = v.d0; wdata[1] = v.d1;
            be[0] = v.b0; be[1] = v.b1;
            #3;
            pop_resp($sformatf("v%0d", i));
            any = |v.gnt;
            p = v.gnt[1] ? 1 : 0;
            check($sformatf("v%0d_gnt", i), 64'(gnt), 64'(v.gnt));
            check($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(any));
            check($sformatf("v%0d_mem_we", i), 64'(mem_we), any ? 64'(we[p]) : 64'h0);
            check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), any ? 64'(addr[p]) : 64'h0);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, any ? wdata[p] : 64'h0);
            check($sformatf("v%0d_mem_be", i), 64'(mem_be), any ? 64'(be[p]) : 64'h0);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'((|v.req) || (|prev_gnt)));
            r.rvalid = v.gnt;
            r.rdata  = (any && !we[p]) ? ref_mem[addr[p][7:0]] : 64'h0;
            sb.push_back(r);
            if (any && we[p])
                for (int b = 0; b < 8; b++)
                    if (be[p][b]) ref_mem[addr[p][7:0]][8*b +: 8] = wdata[p][8*b +: 8];
            prev_gnt = v.gnt;
        end
        while (sb.size() > 0) begin
            @(negedge clk);
            idle_inputs();
            #3;
            pop_resp("drain");
        end

        // Reset asserted in the cycle of a read grant discards its response.
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr[0] = 18'h5;
        #3;
        check("rstmid_gnt_before", 64'(gnt), 64'h1);
        rst = 1'b1;
        #1;
        check("rstmid_gnt_in_rst", 64'(gnt), 64'h0);
        @(posedge clk);
        #1;
        check("rstmid_rvalid", 64'(rvalid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b10; addr[0] = 18'h0; addr[1] = 18'h6;
        #3;
        check("rstmid_rvalid_after", 64'(rvalid), 64'h0);
        check("post_rst_gnt_p1", 64'(gnt), 64'h2);
        @(posedge clk);
        #1;
        check("post_rst_rvalid", 64'(rvalid), 64'h2);
        check("post_rst_rdata", rdata, ref_mem[6]);

        // Single requester past the burst limit keeps its grant.
        do_reset();
        exp_burst = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req = 2'b10; addr[1] = 18'(i);
            #3;
            check($sformatf("solo_gnt%0d", i), 64'(gnt), 64'h2);
            @(posedge clk);
            #1;
            check($sformatf("solo_burst%0d", i), 64'(dut.r_burst_cnt), 64'(exp_burst[i]));
        end

        // Three ports, MaxBurst=1: strict rotation and busy tail.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req3 = 3'b111;
            #3;
            check($sformatf("rr3_gnt%0d", i), 64'(gnt3), 64'(3'b001 << (i % 3)));
            check($sformatf("rr3_busy%0d", i), 64'(busy3), 64'h1);
        end
        @(negedge clk);
        req3 = 3'b000;
        #3;
        check("rr3_gnt_idle", 64'(gnt3), 64'h0);
        check("rr3_last_rvalid", 64'(rvalid3), 64'h4);
        check("rr3_busy_tail", 64'(busy3), 64'h1);
        @(negedge clk);
        #3;
        check("rr3_rvalid_done", 64'(rvalid3), 64'h0);
        check("rr3_busy_low", 64'(busy3), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
